fare_display_scan: RTL and testbench

- Reads the 5-digit BCD fare produced by the price meter and drives a 5-digit multiplexed common-anode 7-segment display.
- Source selection: running fare while the taxi is in MOVE/WAIT; locked last fare while IDLE.
- Provides frame-synchronous snapshotting (no digit tearing), leading-zero blanking, decimal point placement and BCD error flagging.

---
 rtl/fare_display_scan.sv | 151 +++++++++++++++
 tb/tb_fare_display_scan.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fare_display_scan.sv
// fare_display_scan: scans a 5-digit BCD fare onto a multiplexed common-anode 7-segment display.
// A frame is 5 digit slots of SCAN_DIV clocks each. The fare is snapshotted once per frame, so a frame never mixes two fares.
// Optional LOCK_BLINK_EN: after the trip ends, the display blinks for BLINK_HALVES half-periods.
module fare_display_scan #(
  parameter int SCAN_DIV     = 2500,
  parameter int BLINK_HALF   = 5000,
  parameter int BLINK_HALVES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  state,
  input  logic [19:0] price,
  input  logic [19:0] price_locked,
  output logic [4:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        err
);

  localparam int            PW       = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          idle;
  logic [2:0]    idx;
  logic [2:0]    idx_nxt;
  logic [19:0]   shadow;
  logic [19:0]   shadow_nxt;
  logic [19:0]   src;
  logic [3:0]    nib;
  logic [6:0]    seg_nxt;
  logic [4:0]    an_reg;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  function automatic logic has_non_bcd(input logic [19:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // 2'b10 is an undefined code and is shown as if the taxi were idle
  assign idle = (state == 2'b00) || (state == 2'b10);
  assign src  = idle ? price_locked : price;
  assign tick = (pre_cnt == PRE_LAST);

  // Prescaler: one tick per digit slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Next slot, next snapshot and the segment pattern that slot will show
  always_comb begin
    idx_nxt    = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    shadow_nxt = (idx == 3'd4) ? src : shadow;
    case (idx_nxt)
      3'd0:    nib = shadow_nxt[3:0];
      3'd1:    nib = shadow_nxt[7:4];
      3'd2:    nib = shadow_nxt[11:8];
      3'd3:    nib = shadow_nxt[15:12];
      default: nib = shadow_nxt[19:16];
    endcase
    seg_nxt = seg_code(nib);
    // only the tens digit is blanked; the units digit always shows
    if (idx_nxt == 3'd4 && nib == 4'd0) seg_nxt = 7'h7F;
  end

  // Scan state and registered display outputs, all advancing together on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= 3'd4;
      shadow <= '0;
      an_reg <= 5'b11111;
      seg    <= 7'h7F;
      dp     <= 1'b1;
      err    <= 1'b0;
    end else if (tick) begin
      idx    <= idx_nxt;
      shadow <= shadow_nxt;
      an_reg <= ~(5'b00001 << idx_nxt);
      seg    <= seg_nxt;
      dp     <= (idx_nxt != 3'd3);
      if (idx == 3'd4) err <= has_non_bcd(src);
    end
  end

`ifdef LOCK_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int HW = (BLINK_HALVES > 1) ? $clog2(BLINK_HALVES) : 1;

  logic          prev_idle;
  logic          blink_act;
  logic [BW-1:0] blink_cnt;
  logic [HW-1:0] half_cnt;

  // Blink sequencer: restarts on every MOVE/WAIT -> IDLE edge, aborts when IDLE is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_idle <= 1'b1;
      blink_act <= 1'b0;
      blink_cnt <= '0;
      half_cnt  <= '0;
    end else begin
      prev_idle <= idle;
      if (idle && !prev_idle) begin
        blink_act <= 1'b1;
        blink_cnt <= '0;
        half_cnt  <= '0;
      end else if (!idle) begin
        blink_act <= 1'b0;
      end else if (blink_act) begin
        if (blink_cnt == BW'(BLINK_HALF - 1)) begin
          blink_cnt <= '0;
          if (half_cnt == HW'(BLINK_HALVES - 1)) blink_act <= 1'b0;
          else                                   half_cnt  <= half_cnt + 1'b1;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // odd halves switch all anodes off; segments keep scanning underneath
  assign an = an_reg | {5{blink_act & half_cnt[0]}};
`else
  assign an = an_reg;
`endif

endmodule

// File: tb/tb_fare_display_scan.sv
// tb_fare_display_scan: directed steps then random fares/states against a frame-level reference model.
// The model derives slot and snapshot timing from the edge count since reset.
// Outputs are compared on every falling edge.
`timescale 1ns/1ps
module tb_fare_display_scan;
  localparam int D   = 4;
  localparam int BH  = 8;
  localparam int BHV = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  state = 2'b01;
  logic [19:0] price = 20'h09000;
  logic [19:0] price_locked = 20'h00000;
  logic [4:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        err;

  int checks = 0;
  int errors = 0;

  fare_display_scan #(.SCAN_DIV(D), .BLINK_HALF(BH), .BLINK_HALVES(BHV)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .price(price),
    .price_locked(price_locked), .an(an), .seg(seg), .dp(dp), .err(err));

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;  4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;  4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;  4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;  4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;  4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Reference model: edge n after reset is a slot boundary when n is a multiple of D;
  // boundary t shows slot (t-1)%5, and slot 0 takes a new snapshot.
  int          n_edge = 0;
  int          m_slot = 0;
  logic [19:0] m_shadow = '0;
  logic [3:0]  m_nib = '0;
  logic        m_err = 1'b0;
  logic [4:0]  m_an = 5'h1F;
  logic [6:0]  m_seg = 7'h7F;
  logic        m_dp = 1'b1;
  logic        m_idle = 1'b0;
  logic        m_prev_idle = 1'b1;
  int          m_bk = 0;
  logic        m_blank = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edge = 0; m_shadow = '0; m_err = 1'b0; m_an = 5'h1F; m_seg = 7'h7F; m_dp = 1'b1;
      m_prev_idle = 1'b1; m_bk = 0; m_blank = 1'b0;
    end else begin
      m_idle = !(state == 2'b01 || state == 2'b11);
      n_edge++;
      if (n_edge % D == 0) begin
        m_slot = ((n_edge / D) - 1) % 5;
        if (m_slot == 0) begin
          m_shadow = m_idle ? price_locked : price;
          m_err = 1'b0;
          for (int i = 0; i < 5; i++)
            if (4'(m_shadow >> (4 * i)) > 4'd9) m_err = 1'b1;
        end
        m_nib = 4'(m_shadow >> (4 * m_slot));
        m_an  = ~(5'b00001 << m_slot);
        m_seg = (m_slot == 4 && m_nib == 4'd0) ? 7'h7F : seg_of(m_nib);
        m_dp  = (m_slot != 3);
      end
`ifdef LOCK_BLINK_EN
      // m_bk = 1-based cycle number inside the blink window, 0 when not blinking
      if (m_idle && !m_prev_idle) m_bk = 1;
      else if (!m_idle) m_bk = 0;
      else if (m_bk != 0 && m_bk <= BH * BHV) m_bk++;
      m_prev_idle = m_idle;
      m_blank = (m_bk != 0) && (m_bk <= BH * BHV) && (((m_bk - 1) / BH) % 2 == 1);
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("an",  32'(an),  32'(m_an | {5{m_blank}}));
    chk("seg", 32'(seg), 32'(m_seg));
    chk("dp",  32'(dp),  32'(m_dp));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic wait_an(input logic [4:0] pat, input string tag);
    int k = 0;
    while (an !== pat && k < 100) begin
      step();
      k++;
    end
    chk({tag, "_reach"}, 32'(an === pat), 32'd1);
  endtask

  function automatic logic [19:0] rnd_fare();
    logic [19:0] v;
    for (int i = 0; i < 5; i++)
      v[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_an", 32'(an), 32'h1F);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // 1: MOVE, 09000; units slot shows 9 with dp, tens blanked, 4-cycle slots
    wait_an(5'b10111, "t1_d3");
    chk("t1_d3_seg", 32'(seg), 32'b0010000);
    chk("t1_d3_dp", 32'(dp), 32'd0);
    run = 0;
    while (an === 5'b10111 && run < 20) begin step(); run++; end
    chk("t1_run", 32'(run), 32'd4);
    wait_an(5'b01111, "t1_d4");
    chk("t1_d4_seg", 32'(seg), 32'h7F);
    wait_an(5'b11110, "t1_d0");
    chk("t1_d0_seg", 32'(seg), 32'b1000000);
    chk("t1_err", 32'(err), 32'd0);
    repeat (20) step();

    // 2: IDLE shows the locked fare; switching to MOVE mid-frame waits for the frame end
    state = 2'b00; price_locked = 20'h12345;
    repeat (25) step();
    wait_an(5'b11110, "t2_d0");
    chk("t2_d0_seg", 32'(seg), 32'b0010010);
    wait_an(5'b10111, "t2_d3");
    chk("t2_d3_seg", 32'(seg), 32'b0100100);
    wait_an(5'b01111, "t2_d4");
    chk("t2_d4_seg", 32'(seg), 32'b1111001);
    wait_an(5'b11110, "t2_d0b");
    state = 2'b01;
    wait_an(5'b01111, "t2_d4b");
    chk("t2_d4b_seg", 32'(seg), 32'b1111001);
    wait_an(5'b11110, "t2_d0c");
    chk("t2_d0c_seg", 32'(seg), 32'b1000000);
    wait_an(5'b10111, "t2_d3c");
    chk("t2_d3c_seg", 32'(seg), 32'b0010000);

    // 3: mid-frame price change appears only from the next frame
    wait_an(5'b11101, "t3_d1");
    price = 20'h09240;
    wait_an(5'b11011, "t3_d2old");
    chk("t3_d2old_seg", 32'(seg), 32'b1000000);
    wait_an(5'b01111, "t3_d4");
    wait_an(5'b11110, "t3_d0");
    wait_an(5'b11101, "t3_d1new");
    chk("t3_d1new_seg", 32'(seg), 32'b0011001);
    wait_an(5'b11011, "t3_d2new");
    chk("t3_d2new_seg", 32'(seg), 32'b0100100);

    // 4: non-BCD digit shows dash and sets err until the next clean snapshot
    price = 20'h0A000;
    wait_an(5'b01111, "t4_d4");
    wait_an(5'b11110, "t4_d0");
    chk("t4_err_set", 32'(err), 32'd1);
    wait_an(5'b10111, "t4_d3");
    chk("t4_dash", 32'(seg), 32'b0111111);
    price = 20'h09000;
    wait_an(5'b01111, "t4_d4b");
    chk("t4_err_hold", 32'(err), 32'd1);
    wait_an(5'b11110, "t4_d0b");
    chk("t4_err_clr", 32'(err), 32'd0);

    // 5: async reset mid-frame at idx 2 while err is set
    price = 20'h0A000;
    wait_an(5'b01111, "t5_d4");
    wait_an(5'b11110, "t5_d0");
    wait_an(5'b11011, "t5_d2");
    chk("t5_err_pre", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_an", 32'(an), 32'h1F);
    chk("t5_seg", 32'(seg), 32'h7F);
    chk("t5_dp", 32'(dp), 32'd1);
    chk("t5_err", 32'(err), 32'd0);
    price = 20'h09000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= D; k++) begin
      step();
      chk("t5_first", 32'(an), (k < D) ? 32'h1F : 32'h1E);
    end

    // random states and fares, every cycle compared against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) state = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) price = rnd_fare();
      if ($urandom_range(0, 19) == 0) price_locked = rnd_fare();
      step();
    end

`ifdef LOCK_BLINK_EN
    // 6: blink after MOVE -> IDLE, abort on leaving IDLE
    state = 2'b01;
    repeat (10) step();
    state = 2'b00;
    for (int k = 1; k <= 56; k++) begin
      step();
      chk("t6_blink", 32'(an === 5'h1F), 32'((k <= BH * BHV) && (((k - 1) / BH) % 2 == 1)));
    end
    state = 2'b01;
    repeat (5) step();
    state = 2'b00;
    repeat (28) step();
    chk("t6_half3", 32'(an), 32'h1F);
    state = 2'b01;
    step();
    chk("t6_abort", 32'(an !== 5'h1F), 32'd1);
    repeat (10) step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
